// File: rtl/brisc_mem_responder.sv
// brisc_mem_responder
//   Main-memory responder at the far end of the L1 line fill/writeback
//   interface. It accepts one line read or write at a time and answers
//   LATENCY cycles after acceptance. Storage is never reset, so its
//   contents persist across reset.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_write, req_addr, req_data   request payload (addr[3:0] ignored)
//   resp_valid/resp_ready      response handshake (payload held until taken)
//   resp_write, resp_addr, resp_data, resp_err   response payload
//
// Optional feature macro: BRISC_MEM_ERR_EN
//   defined   : line index >= MEM_LINES flags resp_err, the write is dropped,
//               and a read returns zero
//   undefined : line index wraps modulo MEM_LINES, resp_err stays 0
module brisc_mem_responder #(
  parameter int LATENCY   = 5,
  parameter int MEM_LINES = 4096,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [LINE_W-1:0] resp_data,
  output logic              resp_err
);

  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int LINE_A = ADDR_W - 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               lat_write_q, lat_write_d;
  logic [LINE_A-1:0]  lat_line_q, lat_line_d;
  logic [LINE_W-1:0]  lat_data_q, lat_data_d;
  logic               lat_err_q, lat_err_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_write_q, resp_write_d;
  logic [ADDR_W-1:0]  resp_addr_q, resp_addr_d;
  logic [LINE_W-1:0]  resp_data_q, resp_data_d;
  logic               resp_err_q, resp_err_d;

  logic [LINE_W-1:0]  mem [MEM_LINES];

  logic               accept;
  logic               req_oor;
  logic               mem_we;
  logic               load_resp;
  logic               use_req;
  logic               src_write;
  logic               src_err;
  logic [LINE_A-1:0]  src_line;
  logic [LINE_W-1:0]  src_data;
  logic [IDX_W-1:0]   src_idx;
  logic               unused_addr_lsbs;

  assign unused_addr_lsbs = ^req_addr[3:0];
  assign accept = req_valid && req_ready_q;

`ifdef BRISC_MEM_ERR_EN
  assign req_oor = |req_addr[ADDR_W-1:4+IDX_W];
`else
  assign req_oor = 1'b0;
`endif

  // Response source: with LATENCY==1 the response is loaded straight from
  // the request on the acceptance edge, otherwise from the latched copy.
  assign use_req   = (state_q == S_IDLE);
  assign src_write = use_req ? req_write : lat_write_q;
  assign src_err   = use_req ? req_oor : lat_err_q;
  assign src_line  = use_req ? req_addr[ADDR_W-1:4] : lat_line_q;
  assign src_data  = use_req ? req_data : lat_data_q;
  assign src_idx   = src_line[IDX_W-1:0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_write_d  = lat_write_q;
    lat_line_d   = lat_line_q;
    lat_data_d   = lat_data_q;
    lat_err_d    = lat_err_q;
    resp_write_d = resp_write_q;
    resp_addr_d  = resp_addr_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    mem_we       = 1'b0;
    load_resp    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lat_write_d = req_write;
          lat_line_d  = req_addr[ADDR_W-1:4];
          lat_data_d  = req_data;
          lat_err_d   = req_oor;
          mem_we      = req_write && !req_oor;
          cnt_d       = 8'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d   = S_RESP;
            load_resp = 1'b1;
          end else begin
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // The counter reaches 0 on the same edge that enters RESP, which
        // puts resp_valid exactly LATENCY cycles after acceptance.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d   = S_RESP;
          load_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_resp) begin
      resp_write_d = src_write;
      resp_addr_d  = {src_line, 4'b0000};
      resp_err_d   = src_err;
      if (src_write)    resp_data_d = src_data;
      else if (src_err) resp_data_d = '0;
      else              resp_data_d = mem[src_idx];
    end
  end

  assign req_ready_d  = (state_d == S_IDLE);
  assign resp_valid_d = (state_d == S_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      lat_write_q  <= 1'b0;
      lat_line_q   <= '0;
      lat_data_q   <= '0;
      lat_err_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      lat_write_q  <= lat_write_d;
      lat_line_q   <= lat_line_d;
      lat_data_q   <= lat_data_d;
      lat_err_q    <= lat_err_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_addr_q  <= resp_addr_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage has no reset; a write commits on its acceptance edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem[req_addr[4 +: IDX_W]] <= req_data;
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_write = resp_write_q;
  assign resp_addr  = resp_addr_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_brisc_mem_responder.sv
module tb_brisc_mem_responder;
  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_data = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic         resp_write;
  logic [31:0]  resp_addr;
  logic [127:0] resp_data;
  logic         resp_err;

  brisc_mem_responder #(.LATENCY(LAT), .MEM_LINES(4096), .ADDR_W(32), .LINE_W(128)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_addr(resp_addr), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           acc;
    bit           w;
    logic [31:0]  addr;
    logic [127:0] data;
    bit           err;
  } exp_t;
  exp_t sb[$];

  localparam logic [127:0] D0 = 128'hA5A5_5A5A_0F0F_F0F0_1111_2222_3333_4444;
  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] D2 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002;
  localparam logic [127:0] D3 = 128'h1357_9BDF_2468_ACE0_FEDC_BA98_7654_3210;
  localparam logic [127:0] D4 = 128'h3000_3000_ABCD_0000_0000_EF01_3000_3000;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: first response cycle checks latency and payload, later cycles
  // check the payload is held; the handshake retires the expectation.
  bit           holding = 0;
  logic         h_write;
  logic [31:0]  h_addr;
  logic [127:0] h_data;
  logic         h_err;

  always @(negedge clk) begin
    if (reset) holding = 0;
    else if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        if (!holding) begin
          holding = 1;
          h_write = resp_write; h_addr = resp_addr; h_data = resp_data; h_err = resp_err;
          chk("latency", cyc, sb[0].acc + LAT);
          chk("resp_write", resp_write, sb[0].w);
          chk("resp_addr", resp_addr, sb[0].addr);
          chk("resp_data", resp_data, sb[0].data);
          chk("resp_err", resp_err, sb[0].err);
        end else begin
          chk("hold_data", resp_data, h_data);
          chk("hold_addr", resp_addr, h_addr);
          chk("hold_write", resp_write, h_write);
          chk("hold_err", resp_err, h_err);
        end
        if (resp_ready) begin
          void'(sb.pop_front());
          holding = 0;
        end
      end
    end
  end

  // Present a request and block until accepted; leaves req_valid low
  // afterwards unless the caller immediately issues another request.
  task automatic send(input bit w, input logic [31:0] a, input logic [127:0] d,
                      input logic [31:0] ea, input logic [127:0] ed, input bit ee,
                      output int acc);
    exp_t e;
    bit   done = 0;
    acc = -1;
    req_write = w; req_addr = a; req_data = d; req_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        e.acc = cyc; e.w = w; e.addr = ea; e.data = w ? d : ed; e.err = ee;
        sb.push_back(e);
        done = 1;
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  int a1, a2, an;
  int seen;
  bit got;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_addr", resp_addr, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", req_ready, 0);
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);
    @(posedge clk); #1;

    // Line 0 and line 0x100 writes, then reads (aligned and unaligned)
    send(1, 32'h0000_0000, D0, 32'h0000_0000, '0, 0, a1);
    send(1, 32'h0000_1000, D1, 32'h0000_1000, '0, 0, a1);
    send(0, 32'h0000_1000, '0, 32'h0000_1000, D1, 0, a1);
    send(0, 32'h0000_100C, '0, 32'h0000_1000, D1, 0, a1);
    drain();

    // Response stall for 7 cycles with a second request waiting
    resp_ready = 1'b0;
    send(0, 32'h0000_1000, '0, 32'h0000_1000, D1, 0, a1);
    req_write = 1'b0; req_addr = 32'h0000_0000; req_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1;
    end
    chk("stall_resp_seen", got, 1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_resp_valid", resp_valid, 1);
    end
    @(posedge clk); #1; resp_ready = 1'b1;
    send(0, 32'h0000_0000, '0, 32'h0000_0000, D0, 0, a2);
    chk("accept_after_hs", a2, a1 + LAT + 8);
    drain();

    // Back-to-back reads with req_valid held high
    send(1, 32'h0000_2000, D2, 32'h0000_2000, '0, 0, a1);
    send(1, 32'h0000_2010, D3, 32'h0000_2010, '0, 0, a1);
    drain();
    send(0, 32'h0000_2000, '0, 32'h0000_2000, D2, 0, a1);
    send(0, 32'h0000_2010, '0, 32'h0000_2010, D3, 0, a2);
    chk("b2b_accept", a2, a1 + LAT + 1);
    drain();

    // Reset during WAIT of a write
    send(1, 32'h0000_3000, D4, 32'h0000_3000, '0, 0, a1);
    @(posedge clk); #3; reset = 1'b1;
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_resp_addr", resp_addr, 0);
    chk("midrst_resp_data", resp_data, 0);
    chk("midrst_resp_write", resp_write, 0);
    sb.delete();
    @(posedge clk); #1; reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("no_resp_after_rst", seen, 0);
    @(posedge clk); #1;
    send(0, 32'h0000_3000, '0, 32'h0000_3000, D4, 0, a1);
    drain();

    // Out-of-range index 4096
`ifdef BRISC_MEM_ERR_EN
    send(0, 32'h0001_0000, '0, 32'h0001_0000, '0, 1, an);
`else
    send(0, 32'h0001_0000, '0, 32'h0001_0000, D0, 0, an);
`endif
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
